// File: rtl/uart_write_arbiter_n_pkg.sv
// Shared constants for the UART write arbiter: arbitration modes and default word width.
package uart_write_arbiter_n_pkg;

   localparam int unsigned ARB_STATIC = 0;
   localparam int unsigned ARB_RR     = 1;
   localparam int unsigned UART_DW    = 32;

   // Out-of-range static selections fall back to channel 0.
   function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned nch);
      return (sel < nch) ? sel : 0;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request strictly after ptr, wrapping modulo NCH.
module uart_rr_pick #(
   parameter int unsigned NCH = 4,
   parameter int unsigned PW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [PW-1:0]  ptr,
   output logic [PW-1:0]  gnt_idx,
   output logic           gnt_vld
);

   // Walk from farthest to nearest so the nearest requester overrides.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = int'(NCH); k >= 1; k--) begin
         if (req[(32'(ptr) + 32'(k)) % NCH]) begin
            gnt_idx = PW'((32'(ptr) + 32'(k)) % NCH);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_write_arbiter_n.sv
// N-channel arbiter merging producer words into the UART TX FIFO write port,
// with one-word holding register per channel, static or round-robin grant.
module uart_write_arbiter_n
   import uart_write_arbiter_n_pkg::*;
#(
   parameter int unsigned NCH  = 4,
   parameter int unsigned DW   = UART_DW,
   parameter int unsigned MODE = ARB_STATIC,
   parameter int unsigned SELW = $clog2(NCH)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [SELW-1:0]   ApplyUART,
   input  logic [NCH*DW-1:0] ChWrite,
   input  logic [NCH-1:0]    ChWreq,
   output logic [NCH-1:0]    ChBusy,
   input  logic              UARTFull,
   output logic [DW-1:0]     UARTWrite,
   output logic              UARTWreq,
   output logic [NCH-1:0]    Overflow,
   input  logic              ClrOvf
);

   logic [DW-1:0]   hold_q [NCH];
   logic [DW-1:0]   hold_d [NCH];
   logic [NCH-1:0]  valid_q, valid_d;
   logic [NCH-1:0]  ovf_q, ovf_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            wreq_q, wreq_d;

   logic [SELW-1:0] sel_c, pick_idx_c, gnt_c;
   logic            pick_vld_c, issue_c;

   uart_rr_pick #(
      .NCH (NCH),
      .PW  (SELW)
   ) u_pick (
      .req     (valid_q),
      .ptr     (ptr_q),
      .gnt_idx (pick_idx_c),
      .gnt_vld (pick_vld_c)
   );

   // Grant selection; issue is gated by downstream back-pressure.
   always_comb begin
      sel_c   = SELW'(clamp_sel(32'(ApplyUART), NCH));
      gnt_c   = (MODE == ARB_RR) ? pick_idx_c : sel_c;
      issue_c = !UARTFull && ((MODE == ARB_RR) ? pick_vld_c : valid_q[sel_c]);
   end

   always_comb begin
      hold_d  = hold_q;
      valid_d = valid_q;
      ovf_d   = ClrOvf ? '0 : ovf_q;
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      wreq_d  = 1'b0;

      if (issue_c) begin
         wdata_d        = hold_q[gnt_c];
         wreq_d         = 1'b1;
         valid_d[gnt_c] = 1'b0;
         ptr_d          = gnt_c;
      end

      // A slot freed by this cycle's issue can accept a new word; overflow set beats clear.
      for (int i = 0; i < int'(NCH); i++) begin
         if (ChWreq[i]) begin
            if (!valid_q[i] || (issue_c && (gnt_c == SELW'(i)))) begin
               hold_d[i]  = ChWrite[i*DW +: DW];
               valid_d[i] = 1'b1;
            end else begin
               ovf_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         hold_q  <= '{default: '0};
         valid_q <= '0;
         ovf_q   <= '0;
         ptr_q   <= SELW'(NCH - 1);
         wdata_q <= '0;
         wreq_q  <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         ptr_q   <= ptr_d;
         wdata_q <= wdata_d;
         wreq_q  <= wreq_d;
      end
   end

   assign ChBusy    = valid_q;
   assign Overflow  = ovf_q;
   assign UARTWrite = wdata_q;
   assign UARTWreq  = wreq_q;

endmodule

// File: tb/tb_uart_write_arbiter_n.sv
// Directed bench: one static-select and one round-robin arbiter share stimulus.
module tb_uart_write_arbiter_n;

   localparam int unsigned NCH = 4;
   localparam int unsigned DW  = 32;

   logic            Clk = 1'b0;
   logic            Rst;
   logic [1:0]      ApplyUART;
   logic [NCH*DW-1:0] ChWrite;
   logic [NCH-1:0]  ChWreq;
   logic            UARTFull;
   logic            ClrOvf;

   logic [NCH-1:0]  s_busy, r_busy, s_ovf, r_ovf;
   logic [DW-1:0]   s_wr, r_wr;
   logic            s_wreq, r_wreq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   uart_write_arbiter_n #(.NCH(NCH), .DW(DW), .MODE(0)) u_s (
      .Clk(Clk), .Rst(Rst), .ApplyUART(ApplyUART), .ChWrite(ChWrite), .ChWreq(ChWreq),
      .ChBusy(s_busy), .UARTFull(UARTFull), .UARTWrite(s_wr), .UARTWreq(s_wreq),
      .Overflow(s_ovf), .ClrOvf(ClrOvf));

   uart_write_arbiter_n #(.NCH(NCH), .DW(DW), .MODE(1)) u_r (
      .Clk(Clk), .Rst(Rst), .ApplyUART(ApplyUART), .ChWrite(ChWrite), .ChWreq(ChWreq),
      .ChBusy(r_busy), .UARTFull(UARTFull), .UARTWrite(r_wr), .UARTWreq(r_wreq),
      .Overflow(r_ovf), .ClrOvf(ClrOvf));

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1; ApplyUART = '0; ChWrite = '0; ChWreq = '0; UARTFull = 1'b0; ClrOvf = 1'b0;
      tick();
      Rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({s_busy, s_ovf, s_wr, s_wreq} !== '0) begin
         n_fail++; $display("FAIL reset_static: got busy=%b ovf=%b wr=%h wreq=%b, expected all 0", s_busy, s_ovf, s_wr, s_wreq);
      end
      n_checks++;
      if ({r_busy, r_ovf, r_wr, r_wreq} !== '0) begin
         n_fail++; $display("FAIL reset_rr: got busy=%b ovf=%b wr=%h wreq=%b, expected all 0", r_busy, r_ovf, r_wr, r_wreq);
      end
   endtask

   task automatic test_static_latency();
      do_reset();
      ApplyUART = 2'd2;
      ChWrite[2*DW +: DW] = 32'hA5A5_0002; ChWreq = 4'b0100;
      tick();
      ChWreq = '0;
      n_checks++;
      if (s_busy !== 4'b0100 || s_wreq !== 1'b0) begin
         n_fail++; $display("FAIL static_t1: got busy=%b wreq=%b, expected busy=0100 wreq=0", s_busy, s_wreq);
      end
      tick();
      n_checks++;
      if (s_wreq !== 1'b1 || s_wr !== 32'hA5A5_0002 || s_busy !== 4'b0000) begin
         n_fail++; $display("FAIL static_t2: got wreq=%b wr=%h busy=%b, expected 1 a5a50002 0000", s_wreq, s_wr, s_busy);
      end
      tick();
      n_checks++;
      if (s_wreq !== 1'b0 || s_wr !== 32'hA5A5_0002) begin
         n_fail++; $display("FAIL static_t3: got wreq=%b wr=%h, expected 0 a5a50002 (held)", s_wreq, s_wr);
      end
   endtask

   task automatic test_static_blocked();
      int strobes = 0;
      do_reset();
      ApplyUART = 2'd1;
      ChWrite[3*DW +: DW] = 32'h3333_0003; ChWreq = 4'b1000;
      tick();
      ChWreq = '0;
      for (int c = 0; c < 8; c++) begin
         if (s_wreq) strobes++;
         tick();
      end
      n_checks++;
      if (strobes != 0 || s_busy !== 4'b1000) begin
         n_fail++; $display("FAIL static_blocked: got strobes=%0d busy=%b, expected 0 1000", strobes, s_busy);
      end
      ApplyUART = 2'd3;
      tick();
      n_checks++;
      if (s_wreq !== 1'b1 || s_wr !== 32'h3333_0003 || s_busy !== 4'b0000) begin
         n_fail++; $display("FAIL static_select3: got wreq=%b wr=%h busy=%b, expected 1 33330003 0000", s_wreq, s_wr, s_busy);
      end
   endtask

   task automatic test_rr_burst();
      logic [DW-1:0] exp_w;
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 4; i++) ChWrite[i*DW +: DW] = (b == 0) ? 32'hC0DE_0000 + 32'(i) : 32'hBEEF_0000 + 32'(i);
         ChWreq = 4'b1111;
         tick();
         ChWreq = '0;
         n_checks++;
         if (r_busy !== 4'b1111 || r_wreq !== 1'b0) begin
            n_fail++; $display("FAIL rr_capture%0d: got busy=%b wreq=%b, expected 1111 0", b, r_busy, r_wreq);
         end
         for (int i = 0; i < 4; i++) begin
            tick();
            exp_w = (b == 0) ? 32'hC0DE_0000 + 32'(i) : 32'hBEEF_0000 + 32'(i);
            n_checks++;
            if (r_wreq !== 1'b1 || r_wr !== exp_w) begin
               n_fail++; $display("FAIL rr_order b%0d s%0d: got wreq=%b wr=%h, expected 1 %h", b, i, r_wreq, r_wr, exp_w);
            end
         end
      end
      tick();
      n_checks++;
      if (r_wreq !== 1'b0 || r_busy !== 4'b0000) begin
         n_fail++; $display("FAIL rr_drain: got wreq=%b busy=%b, expected 0 0000", r_wreq, r_busy);
      end
   endtask

   task automatic test_full_overflow();
      int strobes = 0;
      do_reset();
      UARTFull = 1'b1;
      ChWrite[1*DW +: DW] = 32'h1111_0001; ChWreq = 4'b0010;
      tick();
      ChWreq = '0;
      for (int c = 0; c < 6; c++) begin if (r_wreq) strobes++; tick(); end
      ChWrite[1*DW +: DW] = 32'h1111_0002; ChWreq = 4'b0010;
      tick();
      ChWreq = '0;
      for (int c = 0; c < 12; c++) begin if (r_wreq) strobes++; tick(); end
      n_checks++;
      if (strobes != 0 || r_ovf !== 4'b0010 || r_busy !== 4'b0010) begin
         n_fail++; $display("FAIL full_hold: got strobes=%0d ovf=%b busy=%b, expected 0 0010 0010", strobes, r_ovf, r_busy);
      end
      UARTFull = 1'b0;
      tick();
      n_checks++;
      if (r_wreq !== 1'b1 || r_wr !== 32'h1111_0001) begin
         n_fail++; $display("FAIL full_release: got wreq=%b wr=%h, expected 1 11110001", r_wreq, r_wr);
      end
      tick();
      n_checks++;
      if (r_wreq !== 1'b0 || r_ovf !== 4'b0010) begin
         n_fail++; $display("FAIL full_single: got wreq=%b ovf=%b, expected 0 0010", r_wreq, r_ovf);
      end
      ClrOvf = 1'b1;
      tick();
      ClrOvf = 1'b0;
      n_checks++;
      if (r_ovf !== 4'b0000) begin
         n_fail++; $display("FAIL clr_ovf: got ovf=%b, expected 0000", r_ovf);
      end
      // Clear coinciding with a fresh overflow: the set must survive.
      UARTFull = 1'b1;
      ChWrite[2*DW +: DW] = 32'h2222_0001; ChWreq = 4'b0100;
      tick();
      ChWrite[2*DW +: DW] = 32'h2222_0002; ClrOvf = 1'b1;
      tick();
      ChWreq = '0; ClrOvf = 1'b0;
      n_checks++;
      if (r_ovf !== 4'b0100) begin
         n_fail++; $display("FAIL ovf_set_wins: got ovf=%b, expected 0100", r_ovf);
      end
      UARTFull = 1'b0;
      tick();
      n_checks++;
      if (r_wreq !== 1'b1 || r_wr !== 32'h2222_0001) begin
         n_fail++; $display("FAIL ovf_first_kept: got wreq=%b wr=%h, expected 1 22220001", r_wreq, r_wr);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ApplyUART = 2'd0;
      ChWrite[0 +: DW] = 32'h0A0A_0001; ChWreq = 4'b0001;
      tick();
      ChWrite[0 +: DW] = 32'h0B0B_0002;
      tick();
      ChWreq = '0;
      n_checks++;
      if (r_wreq !== 1'b1 || r_wr !== 32'h0A0A_0001 || r_busy !== 4'b0001 || r_ovf !== 4'b0000) begin
         n_fail++; $display("FAIL b2b_rr_first: got wreq=%b wr=%h busy=%b ovf=%b, expected 1 0a0a0001 0001 0000", r_wreq, r_wr, r_busy, r_ovf);
      end
      n_checks++;
      if (s_wreq !== 1'b1 || s_wr !== 32'h0A0A_0001 || s_ovf !== 4'b0000) begin
         n_fail++; $display("FAIL b2b_static_first: got wreq=%b wr=%h ovf=%b, expected 1 0a0a0001 0000", s_wreq, s_wr, s_ovf);
      end
      tick();
      n_checks++;
      if (r_wreq !== 1'b1 || r_wr !== 32'h0B0B_0002 || r_busy !== 4'b0000 || r_ovf !== 4'b0000) begin
         n_fail++; $display("FAIL b2b_rr_second: got wreq=%b wr=%h busy=%b ovf=%b, expected 1 0b0b0002 0000 0000", r_wreq, r_wr, r_busy, r_ovf);
      end
      n_checks++;
      if (s_wreq !== 1'b1 || s_wr !== 32'h0B0B_0002) begin
         n_fail++; $display("FAIL b2b_static_second: got wreq=%b wr=%h, expected 1 0b0b0002", s_wreq, s_wr);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      UARTFull = 1'b1;
      for (int i = 0; i < 4; i++) ChWrite[i*DW +: DW] = 32'h5555_0000 + 32'(i);
      ChWreq = 4'b0111;
      tick();
      ChWreq = 4'b1010;
      tick();
      // Requests during the reset cycle must be ignored.
      Rst = 1'b1; ChWreq = 4'b1000;
      tick();
      Rst = 1'b0; ChWreq = '0; UARTFull = 1'b0;
      n_checks++;
      if ({r_busy, r_ovf, r_wr, r_wreq} !== '0) begin
         n_fail++; $display("FAIL rst_mid: got busy=%b ovf=%b wr=%h wreq=%b, expected all 0", r_busy, r_ovf, r_wr, r_wreq);
      end
      tick();
      n_checks++;
      if (r_wreq !== 1'b0 || r_busy !== 4'b0000) begin
         n_fail++; $display("FAIL rst_discard: got wreq=%b busy=%b, expected 0 0000", r_wreq, r_busy);
      end
      ChWreq = 4'b1111;
      tick();
      ChWreq = '0;
      tick();
      n_checks++;
      if (r_wreq !== 1'b1 || r_wr !== 32'h5555_0000) begin
         n_fail++; $display("FAIL rst_first_grant: got wreq=%b wr=%h, expected 1 55550000", r_wreq, r_wr);
      end
   endtask

   initial begin
      test_reset();
      test_static_latency();
      test_static_blocked();
      test_rr_burst();
      test_full_overflow();
      test_back_to_back();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_write_arbiter_n.md
# uart_write_arbiter_n

Parametrised N-channel arbiter merging 32-bit command/result words from several producer modules (master state machine, demodulation channels, frame modules) into the single UART transmit write port. Each channel gets a one-word holding register so producers can pulse a request without waiting for the grant. A configurable arbitration mode selects either external static selection via `ApplyUART` or internal round-robin. Downstream back-pressure and per-channel overflow reporting are included. Sits between the producer modules and the UART TX FIFO write side.

## Interface
Parameters:
- `NCH`, 4: number of requesting channels, 2..8.
- `DW`, 32: word width.
- `MODE`, 0: 0 = static select by `ApplyUART`; 1 = round-robin over all channels.
- `SELW`, clog2(NCH): width of `ApplyUART`.

Ports:
- `Clk`  in  1  single system clock. One clock; reset is synchronous and active-high.
- `Rst`  in  1  synchronous, active-high reset.
- `ApplyUART`  in  SELW  channel select.
  - Used in MODE 0 only.
  - Values ≥ NCH select channel 0.
- `ChWrite`  in  NCH*DW  packed channel words; channel i is `[i*DW +: DW]`.
- `ChWreq`  in  NCH  per-channel single-cycle write request pulses.
- `ChBusy`  out  NCH  holding register of channel i is occupied.
- `UARTFull`  in  1  downstream TX FIFO full; no issue while high.
- `UARTWrite`  out  DW  word to UART TX FIFO, registered.
- `UARTWreq`  out  1  one-cycle write strobe, registered.
- `Overflow`  out  NCH  sticky flag: a request arrived while the channel was busy and was dropped.
- `ClrOvf`  in  1  clears all `Overflow` bits.

## Operation
- **Capture, per channel i:**
  - If `ChWreq[i]` and (`valid[i]`==0, or channel i is being issued this cycle), then `hold[i]`<=slice and `valid[i]`<=1.
  - Otherwise a request is dropped and `Overflow[i]`<=1.
  - `ChBusy` = `valid`.
- **Issue:** evaluated every cycle when `UARTFull`==0. At most one word per cycle.
  - MODE 0: granted channel = `ApplyUART` (or 0 if out of range). Issue only if that channel is valid; other valid channels wait indefinitely.
  - MODE 1: search starts at `ptr+1` mod NCH; the first valid channel is granted; `ptr`<=granted index. `ptr` is unchanged when nothing is issued.
  - On issue: `UARTWrite`<=`hold[g]`, `UARTWreq`<=1, `valid[g]`<=0.
  - Otherwise `UARTWreq`<=0 and `UARTWrite` holds its last value.
- **Simultaneous events:**
  - Issue and new request on the same channel: the new word is captured, `valid` stays 1, no overflow.
  - `ClrOvf` together with a new overflow: the set wins.
- **`UARTFull` high:** nothing issues and nothing is lost. Holding registers fill; further requests on busy channels overflow.
- **Reset:**
  - `valid`=0; pending words are discarded.
  - `ptr`=NCH-1, so channel 0 is checked first.
  - `UARTWrite`=0, `UARTWreq`=0, `Overflow`=0, `ChBusy`=0.
  - Requests presented during the reset cycle are ignored.

## Timing
- `ChWreq` at cycle t → `ChBusy` high at t+1 → earliest `UARTWreq` at t+2 (registered output; no combinational bypass).
- Sustained throughput is 1 word/cycle across channels. A single channel pulsing every cycle gets 1 word/cycle once its pipeline is primed.
- `UARTFull` is sampled in the same cycle as the issue decision. The downstream FIFO must assert full with at least one word of slack.
- MODE 1 fairness: each valid channel is issued within NCH issue cycles.

## Structure
- Shared package:
  - `ARB_STATIC`=0 and `ARB_RR`=1 mode constants.
  - Default `UART_DW`=32.
- Sub-module `uart_rr_pick`:
  - NCH-wide rotating-priority picker.
  - Inputs: request vector, `ptr`.
  - Outputs: grant index, grant-valid.
  - Purely combinational.
- The top holds capture registers, the issue register and `ptr`.

## Test plan
- MODE 0, NCH=4, `ApplyUART`=2: pulse `ChWreq[2]` with 0xA5A50002 at t=10 → `ChBusy[2]`=1 at 11; `UARTWreq`=1 with `UARTWrite`=0xA5A50002 at t=12; `ChBusy[2]`=0 at t=12.
- MODE 0, `ApplyUART`=1, word pending on channel 3 → never issued; set `ApplyUART`=3 → issued within 2 cycles.
- MODE 1: all 4 channels pulse in the same cycle (0x...00 to 0x...03) → four consecutive strobes in order 0,1,2,3. A second burst continues after the last grant.
- `UARTFull`=1 for 20 cycles; channel 1 pulses twice → first word held, `Overflow[1]`=1. Drop full → the single held word is issued. `ClrOvf` → `Overflow[1]`=0.
- Issue and new request on channel 0 in the same cycle → both words appear on `UARTWrite` in order, `Overflow`=0.
- Assert `Rst` while 3 channels are valid → next cycle all outputs 0. After release, the first MODE 1 grant goes to channel 0.
